// File: rtl/mac_dot_ctrl_pkg.sv
// Shared types for the dot-product sequencer: state encoding and its width.
package mac_dot_ctrl_pkg;

    localparam int StateWidth = 3;

    typedef enum logic [StateWidth-1:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDrain  = 3'd2,
        StSettle = 3'd3,
        StResult = 3'd4
    } mac_dot_state_e;

endpackage

// File: rtl/mac_dot_ctrl.sv
// Sequencer that streams operand pairs from two 1-cycle-latency read ports into a
// mac_pe and returns the accumulated dot product over a valid/ready handshake.
module mac_dot_ctrl
    import mac_dot_ctrl_pkg::*;
#(
    parameter int InputDataWidth  = 8,
    parameter int OutputDataWidth = InputDataWidth * 2,
    parameter int AddrWidth       = 8,
    parameter int LenWidth        = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [LenWidth-1:0]        len_i,
    input  logic [AddrWidth-1:0]       a_base_i,
    input  logic [AddrWidth-1:0]       b_base_i,
    output logic                       busy_o,
    output logic                       rd_en_o,
    output logic [AddrWidth-1:0]       a_addr_o,
    output logic [AddrWidth-1:0]       b_addr_o,
    input  logic [InputDataWidth-1:0]  a_rdata_i,
    input  logic [InputDataWidth-1:0]  b_rdata_i,
    output logic [InputDataWidth-1:0]  pe_a_o,
    output logic [InputDataWidth-1:0]  pe_b_o,
    output logic                       pe_a_valid_o,
    output logic                       pe_b_valid_o,
    output logic                       pe_acc_clr_o,
    input  logic [OutputDataWidth-1:0] pe_acc_i,
    output logic [OutputDataWidth-1:0] res_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i
);

    mac_dot_state_e r_state;
    mac_dot_state_e w_stateNext;

    logic [LenWidth-1:0]        r_len;
    logic [LenWidth-1:0]        r_cnt;
    logic [AddrWidth-1:0]       r_aBase;
    logic [AddrWidth-1:0]       r_bBase;
    logic                       r_vld;
    logic                       r_first;
    logic [OutputDataWidth-1:0] r_res;

    logic w_rdEn;
    logic w_lastFetch;

    assign w_rdEn      = (r_state == StFetch);
    assign w_lastFetch = (r_cnt == (r_len - LenWidth'(1)));

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_stateNext = (len_i != '0) ? StFetch : StResult;
                end
            end
            StFetch: begin
                if (w_lastFetch) begin
                    w_stateNext = StDrain;
                end
            end
            StDrain:  w_stateNext = StSettle;
            StSettle: w_stateNext = StResult;
            StResult: begin
                if (res_ready_i) begin
                    w_stateNext = StIdle;
                end
            end
            default:  w_stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Read data arrives one cycle after the strobe, so valid and first-element
    // markers are the read-side conditions delayed by one register stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_aBase <= '0;
            r_bBase <= '0;
            r_vld   <= 1'b0;
            r_first <= 1'b0;
            r_res   <= '0;
        end else begin
            r_vld   <= w_rdEn;
            r_first <= w_rdEn && (r_cnt == '0);
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_len   <= len_i;
                        r_aBase <= a_base_i;
                        r_bBase <= b_base_i;
                        r_cnt   <= '0;
                        if (len_i == '0) begin
                            r_res <= '0;
                        end
                    end
                end
                StFetch:  r_cnt <= r_cnt + LenWidth'(1);
                StSettle: r_res <= pe_acc_i;
                default:  ;
            endcase
        end
    end

    assign busy_o       = (r_state != StIdle);
    assign rd_en_o      = w_rdEn;
    assign a_addr_o     = w_rdEn ? (r_aBase + AddrWidth'(r_cnt)) : '0;
    assign b_addr_o     = w_rdEn ? (r_bBase + AddrWidth'(r_cnt)) : '0;
    assign pe_a_o       = r_vld ? a_rdata_i : '0;
    assign pe_b_o       = r_vld ? b_rdata_i : '0;
    assign pe_a_valid_o = r_vld;
    assign pe_b_valid_o = r_vld;
    assign pe_acc_clr_o = r_vld & r_first;
    assign res_o        = r_res;
    assign res_valid_o  = (r_state == StResult);

endmodule

// File: doc/mac_dot_ctrl.md
# mac_dot_ctrl

Sequencer that drives one `mac_pe` through a complete dot product of run-time length. On `start_i` it latches two operand base addresses and a length. It then streams operand pairs from two 1-cycle-latency read ports into the PE, asserting `acc_clr` on the first pair. It returns the accumulated result over a valid/ready handshake. It sits beside `mac_pe` inside the compute tile, between the operand SRAMs and the result consumer.

## Interface
Parameters:
- `InputDataWidth`, 8, operand width; must match the PE.
- `OutputDataWidth`, `InputDataWidth*2`, accumulator/result width; must match the PE.
- `AddrWidth`, 8, operand memory address width.
- `LenWidth`, 8, vector length width; maximum length is 2^LenWidth-1.

Ports:
- `clk_i` in 1: clock; one clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `start_i` in 1: start request; accepted only in IDLE.
- `len_i` in LenWidth: number of operand pairs; latched on accept.
- `a_base_i`, `b_base_i` in AddrWidth: operand base addresses; latched on accept.
- `busy_o` out 1: high in every state except IDLE.
- `rd_en_o` out 1: read strobe, shared by both memories.
- `a_addr_o`, `b_addr_o` out AddrWidth: read addresses.
- `a_rdata_i`, `b_rdata_i` in InputDataWidth: read data, valid the cycle after `rd_en_o`.
- `pe_a_o`, `pe_b_o` out InputDataWidth: PE operands.
- `pe_a_valid_o`, `pe_b_valid_o` out 1: PE valids; always equal to each other.
- `pe_acc_clr_o` out 1: PE clear-and-load.
- `pe_acc_i` in OutputDataWidth: PE accumulator output.
- `res_o` out OutputDataWidth: result, registered.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: consumer ready.

## Operation
FSM states: IDLE, FETCH, DRAIN, SETTLE, RESULT.
- **IDLE**
  - On `start_i`, latch `len_i` and both bases, and clear element counter `cnt_q`.
  - Go to FETCH if `len_i` != 0.
  - If `len_i` == 0, load `res_q` with 0 and go directly to RESULT.
- **FETCH**
  - `rd_en_o`=1, `a_addr_o`=`a_base`+`cnt_q`, `b_addr_o`=`b_base`+`cnt_q`, both modulo 2^AddrWidth (wrap-around is legal).
  - `cnt_q` increments each cycle.
  - Go to DRAIN after the cycle with `cnt_q`==len-1.
- **Operand path**
  - `rd_en` is delayed one cycle into `vld_q`.
  - `pe_a_o`/`pe_b_o` = `a_rdata_i`/`b_rdata_i` (combinational).
  - `pe_*_valid_o` = `vld_q`.
  - `pe_acc_clr_o` = `vld_q` AND first element. The first pair loads the PE rather than adding to it.
  - When `vld_q`=0, operand outputs are driven to 0.
- **DRAIN**: one cycle; the last pair is presented to the PE. Go to SETTLE.
- **SETTLE**: one cycle; `pe_acc_i` now holds the final sum and `res_q` <= `pe_acc_i`. Go to RESULT.
- **RESULT**
  - `res_valid_o`=1 and `res_o`=`res_q`, both held stable until `res_valid_o` && `res_ready_i`.
  - On that handshake, go to IDLE.
- `start_i` outside IDLE is ignored, including during the handshake cycle.
- Arithmetic is the PE's: products and sums wrap modulo 2^OutputDataWidth. No overflow flag.
- Reset (any state) → IDLE. All outputs are 0, including `res_o` and `pe_acc_clr_o`. `mac_pe` shares `rst_ni`.

## Timing
- `start_i` accepted at cycle T (state IDLE), len=N>0:
  - reads issued T+1..T+N
  - PE inputs valid T+2..T+N+1 (DRAIN at T+N+1)
  - SETTLE at T+N+2
  - `res_valid_o` first high at T+N+3
- N=0: `res_valid_o` first high at T+1.
- If `res_ready_i` is already high, the handshake completes in the first RESULT cycle. `busy_o` is low the next cycle, and a new start is accepted that cycle.
- `busy_o` rises the cycle after accept.
- No back-pressure on the read ports; the memories must return data every cycle.

## Structure
- Package `mac_dot_ctrl_pkg`: the state enum `mac_dot_state_e` and the encoded state width.
- No sub-module inside the controller; the counter and FSM are inline.
- Controller and `mac_pe` are siblings under the tile top. They are wired `pe_*` ↔ PE ports, with `pe_acc_i` ← `acc_o`.

## Test plan
- A[0x10..0x12]={1,2,3}, B[0x20..0x22]={4,5,6}, len=3 → `res_o`=32 with `res_valid_o` at T+6; `pe_acc_clr_o` high only at T+2.
- len=0 → `res_o`=0 at T+1; `rd_en_o` and PE valids never assert.
- A={255,255}, B={255,255}, len=2 → `res_o`=64514 (130050 mod 65536).
- `a_base`=0xFE, len=4 → `a_addr_o` sequence FE,FF,00,01; result correct.
- Hold `res_ready_i` low 5 cycles → `res_o` and `res_valid_o` stable; `start_i` pulsed during this window ignored; `busy_o` stays high.
- Assert `rst_ni` low mid-FETCH → all outputs 0 asynchronously. After release, a new len=3 job returns 32.
